// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter: sends an L-bit pattern MSB first, repeated
// rep_cnt+1 times with optional idle gaps, then pulses done for one cycle.
module seq_pattern_tx #(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned LEN_W = 4,
  parameter int unsigned REP_W = 4,
  parameter int unsigned GAP_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] pat_len,
  input  logic [REP_W-1:0] rep_cnt,
  input  logic [GAP_W-1:0] gap_len,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_d;

  logic [PAT_W-1:0] pat_q;
  logic [PAT_W-1:0] pat_d;
  logic [IDX_W-1:0] lm1_q;
  logic [IDX_W-1:0] lm1_d;
  logic [REP_W-1:0] rep_q;
  logic [REP_W-1:0] rep_d;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_d;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_d;
  logic [GAP_W-1:0] gcnt;
  logic [GAP_W-1:0] gcnt_d;
  logic [IDX_W-1:0] lm1_in;
  logic             load;

  logic             out_d;
  logic             out_valid_d;
  logic             busy_d;
  logic             done_d;

  // Effective length minus one; 0 or oversize lengths mean a full PAT_W pattern
  always_comb begin
    if (pat_len == '0 || pat_len > LEN_W'(PAT_W)) begin
      lm1_in = IDX_W'(PAT_W - 1);
    end else begin
      lm1_in = IDX_W'(pat_len - 1'b1);
    end
  end

  assign load = (state == IDLE) && start && !abort;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic; abort always wins and returns to IDLE
  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (load) state_d = SHIFT;
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (idx == '0) begin
          if (rep_q != '0) state_d = (gap_q != '0) ? GAP : SHIFT;
          else             state_d = DONE;
        end
      end
      GAP: begin
        if (abort)                      state_d = IDLE;
        else if (gcnt <= GAP_W'(1))     state_d = SHIFT;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of shadow registers and counters
  always_comb begin
    pat_d  = pat_q;
    lm1_d  = lm1_q;
    rep_d  = rep_q;
    gap_d  = gap_q;
    idx_d  = idx;
    gcnt_d = gcnt;
    case (state)
      IDLE: begin
        if (load) begin
          pat_d = pattern;
          lm1_d = lm1_in;
          rep_d = rep_cnt;
          gap_d = gap_len;
          idx_d = lm1_in;
        end
      end
      SHIFT: begin
        if (!abort) begin
          if (idx == '0) begin
            if (rep_q != '0) begin
              rep_d  = rep_q - 1'b1;
              idx_d  = lm1_q;
              gcnt_d = gap_q;
            end
          end else begin
            idx_d = idx - 1'b1;
          end
        end
      end
      GAP: begin
        if (!abort && gcnt != '0) gcnt_d = gcnt - 1'b1;
      end
      default: ;
    endcase
  end

  // Next output values, decoded from the upcoming state so outputs come from flops
  always_comb begin
    out_d       = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    if (state_d == SHIFT) begin
      out_d       = pat_d[idx_d];
      out_valid_d = 1'b1;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pat_q     <= '0;
      lm1_q     <= '0;
      rep_q     <= '0;
      gap_q     <= '0;
      idx       <= '0;
      gcnt      <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      pat_q     <= pat_d;
      lm1_q     <= lm1_d;
      rep_q     <= rep_d;
      gap_q     <= gap_d;
      idx       <= idx_d;
      gcnt      <= gcnt_d;
      out       <= out_d;
      out_valid <= out_valid_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule
